// File: rtl/lcb_pkg.sv
// Shared definitions for the LCB link: sequencer/receiver states, default
// timing parameters and the request codes understood by the LCB responder.
package lcb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SEND,
    ST_TRAIL,
    ST_WAIT,
    ST_RECV,
    ST_DONE
  } poll_state_e;

  typedef enum logic [1:0] {
    RX_HUNT,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int ANS_LEN_DEF      = 32;
  localparam int GUARD_DEF        = 8;
  localparam int TIMEOUT_DEF      = 4096;
  localparam int BUF_DEPTH        = 32;

  localparam logic [7:0] REQ_STATUS   = 8'hA5;
  localparam logic [7:0] REQ_COUNTERS = 8'h5A;
  localparam logic [7:0] REQ_IDENT    = 8'h3C;

endpackage

// File: rtl/cfm_poller_if.sv
// Bundle of the poller's command, RS485 line and answer-buffer signals.
interface cfm_poller_if;
  import lcb_pkg::*;

  // start is a one-cycle request honoured only while busy is low; the poll
  // ends with a one-cycle done, after which the error flags and rx_cnt hold.
  logic        start;
  logic [7:0]  req_code;
  logic        RX;
  logic        tx;
  logic        dirTX;
  logic        dirRX;
  logic        busy;
  logic        done;
  logic        err_timeout;
  logic        err_frame;
  logic [5:0]  rx_cnt;
  logic [4:0]  buf_raddr;
  logic [7:0]  buf_rdata;
  poll_state_e dbg_state;

  modport master (
    output start, req_code, RX, buf_raddr,
    input  tx, dirTX, dirRX, busy, done, err_timeout, err_frame, rx_cnt,
    input  buf_rdata, dbg_state
  );

  modport slave (
    input  start, req_code, RX, buf_raddr,
    output tx, dirTX, dirRX, busy, done, err_timeout, err_frame, rx_cnt,
    output buf_rdata, dbg_state
  );

endinterface

// File: rtl/cfm_poller_uart_rx.sv
// 8N1 byte receiver: synchronizes RX, validates the start bit at half-bit,
// samples data and stop mid-bit and pulses valid at the stop sample.
module uart_rx_byte
  import lcb_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       rx_i,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  logic          s1_q, s2_q, s3_q;
  rx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;

  assign data_o = shift_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      s3_q        <= 1'b1;
      state_q     <= RX_HUNT;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      s1_q    <= rx_i;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      valid_o <= 1'b0;
      if (!en_i) begin
        state_q <= RX_HUNT;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          RX_HUNT: begin
            if (s3_q && !s2_q) begin
              state_q <= RX_START;
              cnt_q   <= '0;
            end
          end
          RX_START: begin
            // A line that is high again at half-bit was only a glitch.
            if (cnt_q == HALF_M1) begin
              cnt_q   <= '0;
              bit_q   <= '0;
              state_q <= s2_q ? RX_HUNT : RX_DATA;
            end else begin
              cnt_q <= cnt_q + C_ONE;
            end
          end
          RX_DATA: begin
            if (cnt_q == BIT_M1) begin
              cnt_q   <= '0;
              shift_q <= {s2_q, shift_q[7:1]};
              bit_q   <= bit_q + 3'd1;
              if (bit_q == 3'd7) state_q <= RX_STOP;
            end else begin
              cnt_q <= cnt_q + C_ONE;
            end
          end
          RX_STOP: begin
            if (cnt_q == BIT_M1) begin
              cnt_q       <= '0;
              valid_o     <= 1'b1;
              frame_err_o <= !s2_q;
              state_q     <= RX_HUNT;
            end else begin
              cnt_q <= cnt_q + C_ONE;
            end
          end
          default: state_q <= RX_HUNT;
        endcase
      end
    end
  end

endmodule

// File: rtl/cfm_poller.sv
// CFM-side LCB poller: sends one request byte on RS485, then collects a
// fixed-length answer into a 32x8 buffer with timeout and framing checks.
module cfm_poller
  import lcb_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int ANS_LEN      = ANS_LEN_DEF,
  parameter int GUARD        = GUARD_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  cfm_poller_if.slave  bus
);

  localparam int CMAX = (CLKS_PER_BIT > GUARD) ? CLKS_PER_BIT : GUARD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] GUARD_M1 = CW'(GUARD - 1);
  localparam logic [CW-1:0] BIT_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [TW-1:0] TO_LIM   = TW'(TIMEOUT);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [5:0]    ANS_N    = 6'(ANS_LEN);

  poll_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    bit_q;
  logic [7:0]    req_q;
  logic          tx_q, dir_q, busy_q, done_q, err_to_q, err_fr_q;
  logic [5:0]    rx_cnt_q;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    rdata_q;
  logic [7:0]    mem_q [BUF_DEPTH];
  logic [9:0]    frame;

  logic       rx_en, rx_valid, rx_ferr, wr_en;
  logic [7:0] rx_data;

  assign frame    = {1'b1, req_q, 1'b0};
  assign to_cnt_d = to_cnt_q + T_ONE;
  assign rx_en    = (state_q == ST_WAIT) || (state_q == ST_RECV);
  assign wr_en    = !rst && rx_en && rx_valid && !rx_ferr;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (clk),
    .rst         (rst),
    .en_i        (rx_en),
    .rx_i        (bus.RX),
    .valid_o     (rx_valid),
    .data_o      (rx_data),
    .frame_err_o (rx_ferr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      req_q    <= '0;
      tx_q     <= 1'b1;
      dir_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_to_q <= 1'b0;
      err_fr_q <= 1'b0;
      rx_cnt_q <= '0;
      to_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            req_q    <= bus.req_code;
            rx_cnt_q <= '0;
            err_to_q <= 1'b0;
            err_fr_q <= 1'b0;
            busy_q   <= 1'b1;
            dir_q    <= 1'b1;
            cnt_q    <= '0;
            state_q  <= ST_LEAD;
          end
        end
        ST_LEAD: begin
          if (cnt_q == GUARD_M1) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= ST_SEND;
          end else begin
            cnt_q <= cnt_q + C_ONE;
          end
        end
        ST_SEND: begin
          if (cnt_q == BIT_M1) begin
            cnt_q <= '0;
            if (bit_q == 4'd9) begin
              tx_q    <= 1'b1;
              state_q <= ST_TRAIL;
            end else begin
              bit_q <= bit_q + 4'd1;
              tx_q  <= frame[bit_q + 4'd1];
            end
          end else begin
            cnt_q <= cnt_q + C_ONE;
          end
        end
        ST_TRAIL: begin
          if (cnt_q == GUARD_M1) begin
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            to_cnt_q <= '0;
            state_q  <= ST_WAIT;
          end else begin
            cnt_q <= cnt_q + C_ONE;
          end
        end
        ST_WAIT, ST_RECV: begin
          // A byte's stop sample counts as the first idle cycle of the next gap.
          if (rx_valid) begin
            to_cnt_q <= T_ONE;
            if (rx_ferr) begin
              err_fr_q <= 1'b1;
            end else begin
              rx_cnt_q <= rx_cnt_q + 6'd1;
              state_q  <= ST_RECV;
              if (rx_cnt_q + 6'd1 == ANS_N) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end
            end
          end else if (to_cnt_d == TO_LIM) begin
            state_q  <= ST_DONE;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            err_to_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_d;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[rx_cnt_q[4:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= mem_q[bus.buf_raddr];
  end

  assign bus.tx          = tx_q;
  assign bus.dirTX       = dir_q;
  assign bus.dirRX       = dir_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err_timeout = err_to_q;
  assign bus.err_frame   = err_fr_q;
  assign bus.rx_cnt      = rx_cnt_q;
  assign bus.buf_rdata   = rdata_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_cfm_poller.sv
// Bench for cfm_poller acting as the LCB end of the link: decodes the
// request from tx, answers on RX and checks flags, timing and buffer.
module tb_cfm_poller;
  import lcb_pkg::*;

  localparam int CPB   = 16;
  localparam int ANS   = 32;
  localparam int GUARD = 8;
  localparam int TMO   = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cfm_poller_if bus();

  cfm_poller #(
    .CLKS_PER_BIT (CPB),
    .ANS_LEN      (ANS),
    .GUARD        (GUARD),
    .TIMEOUT      (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int dirfall_cyc = 0;
  logic done_to = 1'b0;
  logic dir_prev = 1'b0;
  int last_mid = 0;
  logic [7:0] exp_q[$];
  logic bad_seen;

  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: records done pulses and the cycle the bus is released.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      done_to  = bus.err_timeout;
    end
    if (dir_prev && bus.dirTX === 1'b0) dirfall_cyc = cyc;
    dir_prev = (bus.dirTX === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_tx"}, bus.tx, 1);
    check({pfx, "_dirTX"}, bus.dirTX, 0);
    check({pfx, "_dirRX"}, bus.dirRX, 0);
    check({pfx, "_busy"}, bus.busy, 0);
    check({pfx, "_done"}, bus.done, 0);
    check({pfx, "_err_to"}, bus.err_timeout, 0);
    check({pfx, "_err_fr"}, bus.err_frame, 0);
    check({pfx, "_rx_cnt"}, bus.rx_cnt, 0);
    check({pfx, "_rdata"}, bus.buf_rdata, 0);
  endtask

  task automatic pulse_start(input logic [7:0] code);
    bus.start = 1'b1;
    bus.req_code = code;
    @(negedge clk);
    bus.start = 1'b0;
    bus.req_code = $urandom_range(0, 255);
    check("busy_next", bus.busy, 1);
    check("dirTX_next", bus.dirTX, 1);
    check("dirRX_next", bus.dirRX, 1);
    check("err_cleared", {bus.err_timeout, bus.err_frame, bus.rx_cnt}, 0);
  endtask

  // Decodes the request as a UART receiver would, sampling each bit mid-cell.
  task automatic watch_request(input logic poke, output logic [7:0] code,
                               output int lead, output int tail, output logic [1:0] framing);
    logic [9:0] bits;
    int n;
    logic tx_hi;
    bits = '1;
    n = 0;
    while (bus.tx === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    lead = n;
    for (int c = 0; c < 10 * CPB; c++) begin
      if (c % CPB == CPB / 2) bits[c / CPB] = bus.tx;
      if (poke && c == 3 * CPB) bus.start = 1'b1;
      if (poke && c == 3 * CPB + 1) bus.start = 1'b0;
      @(negedge clk);
    end
    n = 0;
    tx_hi = 1'b1;
    while (bus.dirTX === 1'b1 && n < 200) begin
      if (bus.tx !== 1'b1) tx_hi = 1'b0;
      @(negedge clk);
      n++;
    end
    tail = n;
    code = bits[8:1];
    framing = {bits[9] & tx_hi, ~bits[0]};
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bus.RX = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.RX = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.RX = stop_bit;
    last_mid = cyc + CPB / 2;
    repeat (CPB) @(negedge clk);
    bus.RX = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic read_buf(input int a, output logic [7:0] d);
    bus.buf_raddr = a[4:0];
    @(negedge clk);
    d = bus.buf_rdata;
  endtask

  // One full poll. n_send bytes are offered (stopping once the answer is
  // complete), bad_idx gets a low stop bit, rst_after>=0 resets mid-answer.
  task automatic run_poll(input logic [7:0] code, input int n_send, input int bad_idx,
                          input logic glitch, input logic poke, input logic seq_data,
                          input int rst_after);
    logic [7:0] got, b, d;
    int lead, tail, d0, n, off;
    logic [1:0] framing;
    logic timed_out;
    exp_q.delete();
    bad_seen = 1'b0;
    d0 = done_cnt;
    pulse_start(code);
    watch_request(poke, got, lead, tail, framing);
    check("req_code", got, code);
    check("req_framing", framing, 2'b11);
    check("lead_guard", lead, GUARD);
    check("trail_guard", tail, GUARD);
    if (glitch) begin
      bus.RX = 1'b0;
      repeat (CPB / 4) @(negedge clk);
      bus.RX = 1'b1;
      repeat (2 * CPB) @(negedge clk);
    end
    for (int i = 0; i < n_send; i++) begin
      if (exp_q.size() >= ANS) break;
      if (i == rst_after) begin
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 0);
        return;
      end
      b = seq_data ? 8'(i) : 8'($urandom_range(0, 255));
      if (i == bad_idx) begin
        send_byte(b, 1'b0);
        bad_seen = 1'b1;
      end else begin
        send_byte(b, 1'b1);
        exp_q.push_back(b);
      end
    end
    n = 0;
    while (done_cnt == d0 && n < TMO + 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", (done_cnt != d0), 1);
    repeat (4) @(negedge clk);
    check("done_single", done_cnt - d0, 1);
    timed_out = (exp_q.size() < ANS);
    check("err_to_at_done", done_to, timed_out);
    check("err_timeout", bus.err_timeout, timed_out);
    check("err_frame", bus.err_frame, bad_seen);
    check("rx_cnt", bus.rx_cnt, exp_q.size());
    check("busy_after", bus.busy, 0);
    if (n_send == 0) begin
      check("to_exact", done_cyc - dirfall_cyc, TMO);
    end else begin
      off = done_cyc - last_mid - (timed_out ? TMO : 0);
      check("done_latency", (off >= 1 && off <= 5), 1);
    end
    foreach (exp_q[i]) begin
      read_buf(i, d);
      check($sformatf("buf[%0d]", i), d, exp_q[i]);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.req_code = '0;
    bus.RX = 1'b1;
    bus.buf_raddr = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    run_poll(8'hA5, 32, -1, 1'b0, 1'b0, 1'b1, -1);
    run_poll(8'($urandom_range(0, 255)), 32, -1, 1'b0, 1'b0, 1'b0, -1);
    run_poll(8'($urandom_range(0, 255)), 0, -1, 1'b0, 1'b0, 1'b0, -1);
    run_poll(8'($urandom_range(0, 255)), 10, -1, 1'b0, 1'b0, 1'b0, -1);
    run_poll(8'($urandom_range(0, 255)), 40, 5, 1'b0, 1'b0, 1'b0, -1);
    run_poll(8'($urandom_range(0, 255)), 32, -1, 1'b1, 1'b1, 1'b0, -1);
    run_poll(8'($urandom_range(0, 255)), 32, -1, 1'b0, 1'b0, 1'b0, 7);
    run_poll(8'($urandom_range(0, 255)), 32, -1, 1'b0, 1'b0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
